// File: rtl/bus_arbiter.sv
// Two-requester arbiter onto a single shared bus, one transaction in flight.
// Reads forward one address beat then return BEATS response beats; writes forward 1+BEATS beats.
module bus_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      r0_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] r0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  r0_reqtag,
    output logic                      r0_reqack,
    output logic                      r0_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] r0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  r0_resptag,
    input  logic                      r0_respack,

    input  logic                      r1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] r1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  r1_reqtag,
    output logic                      r1_reqack,
    output logic                      r1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] r1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  r1_resptag,
    input  logic                      r1_respack,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int unsigned CNT_W   = $clog2(BEATS + 2);
    localparam int unsigned TAG_MSB = BUS_TAG_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner;
    logic             w_owner_nxt;
    logic             r_rr;
    logic             w_rr_nxt;
    logic             r_is_write;
    logic             w_is_write_nxt;
    logic [CNT_W-1:0] r_req_cnt;
    logic [CNT_W-1:0] w_req_cnt_nxt;
    logic [CNT_W-1:0] r_resp_cnt;
    logic [CNT_W-1:0] w_resp_cnt_nxt;
    logic             w_req_fire;
    logic             w_resp_fire;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_rr       <= 1'b0;
            r_is_write <= 1'b0;
            r_req_cnt  <= '0;
            r_resp_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr       <= w_rr_nxt;
            r_is_write <= w_is_write_nxt;
            r_req_cnt  <= w_req_cnt_nxt;
            r_resp_cnt <= w_resp_cnt_nxt;
        end
    end

    // Next-state, grant and forwarding muxes
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_nxt       = r_rr;
        w_is_write_nxt = r_is_write;
        w_req_cnt_nxt  = r_req_cnt;
        w_resp_cnt_nxt = r_resp_cnt;
        w_req_fire     = 1'b0;
        w_resp_fire    = 1'b0;

        r0_reqack   = 1'b0;
        r1_reqack   = 1'b0;
        r0_respcyc  = 1'b0;
        r1_respcyc  = 1'b0;
        r0_resp     = '0;
        r1_resp     = '0;
        r0_resptag  = '0;
        r1_resptag  = '0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r0_reqcyc || r1_reqcyc) begin
                    w_owner_nxt    = (r0_reqcyc && r1_reqcyc) ? r_rr : r1_reqcyc;
                    w_is_write_nxt = w_owner_nxt ? r1_reqtag[TAG_MSB] : r0_reqtag[TAG_MSB];
                    w_req_cnt_nxt  = '0;
                    w_resp_cnt_nxt = '0;
                    w_state_nxt    = S_REQ;
                end
            end

            S_REQ: begin
                bus_reqcyc = r_owner ? r1_reqcyc : r0_reqcyc;
                if (bus_reqcyc) begin
                    bus_req    = r_owner ? r1_req : r0_req;
                    bus_reqtag = r_owner ? r1_reqtag : r0_reqtag;
                end
                r0_reqack  = !r_owner && bus_reqack;
                r1_reqack  = r_owner && bus_reqack;
                w_req_fire = bus_reqcyc && bus_reqack;
                if (w_req_fire) begin
                    if (!r_is_write) begin
                        w_req_cnt_nxt  = '0;
                        w_resp_cnt_nxt = '0;
                        w_state_nxt    = S_RESP;
                    end else if (r_req_cnt == CNT_W'(BEATS)) begin
                        w_req_cnt_nxt = '0;
                        w_rr_nxt      = !r_owner;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_req_cnt_nxt = r_req_cnt + CNT_W'(1);
                    end
                end
            end

            S_RESP: begin
                r0_respcyc  = !r_owner && bus_respcyc;
                r1_respcyc  = r_owner && bus_respcyc;
                if (r0_respcyc) begin
                    r0_resp    = bus_resp;
                    r0_resptag = bus_resptag;
                end
                if (r1_respcyc) begin
                    r1_resp    = bus_resp;
                    r1_resptag = bus_resptag;
                end
                bus_respack = r_owner ? r1_respack : r0_respack;
                w_resp_fire = bus_respcyc && bus_respack;
                if (w_resp_fire) begin
                    if (r_resp_cnt == CNT_W'(BEATS - 1)) begin
                        w_resp_cnt_nxt = '0;
                        w_req_cnt_nxt  = '0;
                        w_rr_nxt       = !r_owner;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_resp_cnt_nxt = r_resp_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs stay quiet while reset is held, even before the reset edge lands
        if (!reset) begin
            r0_reqack   = 1'b0;
            r1_reqack   = 1'b0;
            r0_respcyc  = 1'b0;
            r1_respcyc  = 1'b0;
            r0_resp     = '0;
            r1_resp     = '0;
            r0_resptag  = '0;
            r1_resptag  = '0;
            bus_reqcyc  = 1'b0;
            bus_req     = '0;
            bus_reqtag  = '0;
            bus_respack = 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: read, stalled write, contention and mid-response reset.
module tb_bus_arbiter;

    localparam int unsigned DW    = 64;
    localparam int unsigned TW    = 13;
    localparam int unsigned BEATS = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_reqcyc, r1_reqcyc;
    logic [DW-1:0] r0_req, r1_req;
    logic [TW-1:0] r0_reqtag, r1_reqtag;
    logic          r0_reqack, r1_reqack;
    logic          r0_respcyc, r1_respcyc;
    logic [DW-1:0] r0_resp, r1_resp;
    logic [TW-1:0] r0_resptag, r1_resptag;
    logic          r0_respack, r1_respack;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;

    int n_vec = 0;
    int n_err = 0;
    int acks;

    always #5 clk = ~clk;

    bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(BEATS)) u_dut (
        .clk(clk), .reset(reset),
        .r0_reqcyc(r0_reqcyc), .r0_req(r0_req), .r0_reqtag(r0_reqtag), .r0_reqack(r0_reqack),
        .r0_respcyc(r0_respcyc), .r0_resp(r0_resp), .r0_resptag(r0_resptag), .r0_respack(r0_respack),
        .r1_reqcyc(r1_reqcyc), .r1_req(r1_req), .r1_reqtag(r1_reqtag), .r1_reqack(r1_reqack),
        .r1_respcyc(r1_respcyc), .r1_resp(r1_resp), .r1_resptag(r1_resptag), .r1_respack(r1_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n response beats base..base+n-1 to the given owner, optional one-cycle stall at beat 3
    task automatic resp_beats(input logic owner, input int n, input logic [63:0] base, input bit stall);
        for (int i = 0; i < n; i++) begin
            if (stall && i == 3) begin
                bus_respcyc = 1'b1;
                bus_resp    = base + 64'(i);
                r0_respack  = 1'b0;
                r1_respack  = 1'b0;
                #1;
                chk("resp_stall_ack", 64'(bus_respack), 64'd0);
                tick();
            end
            bus_respcyc = 1'b1;
            bus_resp    = base + 64'(i);
            bus_resptag = TW'(i + 1);
            r0_respack  = !owner;
            r1_respack  = owner;
            #1;
            chk("resp_cyc", 64'(owner ? r1_respcyc : r0_respcyc), 64'd1);
            chk("resp_other", 64'(owner ? r0_respcyc : r1_respcyc), 64'd0);
            chk("resp_data", owner ? r1_resp : r0_resp, base + 64'(i));
            chk("resp_tag", 64'(owner ? r1_resptag : r0_resptag), 64'(i + 1));
            chk("resp_busack", 64'(bus_respack), 64'd1);
            chk("resp_noreqack", 64'(r0_reqack | r1_reqack), 64'd0);
            tick();
        end
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
        r0_respack  = 1'b0;
        r1_respack  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        r0_reqcyc = 1'b0; r0_req = '0; r0_reqtag = '0; r0_respack = 1'b0;
        r1_reqcyc = 1'b0; r1_req = '0; r1_reqtag = '0; r1_respack = 1'b0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;

        // Reset state, with activity on the inputs
        tick();
        r0_reqcyc = 1'b1; r0_req = 64'h55; bus_respcyc = 1'b1; r0_respack = 1'b1; bus_reqack = 1'b1;
        tick();
        chk("rst_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("rst_bus_req", bus_req, 64'd0);
        chk("rst_reqack", 64'(r0_reqack | r1_reqack), 64'd0);
        chk("rst_respcyc", 64'(r0_respcyc | r1_respcyc), 64'd0);
        chk("rst_respack", 64'(bus_respack), 64'd0);
        bus_respcyc = 1'b0; r0_respack = 1'b0; bus_reqack = 1'b0; r0_reqcyc = 1'b0; r0_req = '0;
        tick();

        // r0 read at 0x1000
        reset = 1'b1;
        r0_reqcyc = 1'b1; r0_req = 64'h1000; r0_reqtag = 13'h0003;
        #1;
        chk("rd_idle_noreq", 64'(bus_reqcyc), 64'd0);
        tick();
        chk("rd_grant", 64'(bus_reqcyc), 64'd1);
        chk("rd_addr", bus_req, 64'h1000);
        chk("rd_tag", 64'(bus_reqtag), 64'h3);
        chk("rd_ack_wait", 64'(r0_reqack), 64'd0);
        tick();
        bus_reqack = 1'b1;
        #1;
        chk("rd_ack", 64'(r0_reqack), 64'd1);
        chk("rd_ack_other", 64'(r1_reqack), 64'd0);
        tick();
        chk("rd_resp_noreq", 64'(bus_reqcyc), 64'd0);
        chk("rd_resp_nodata", bus_req, 64'd0);
        chk("rd_resp_noack", 64'(r0_reqack), 64'd0);
        r0_reqcyc = 1'b0; bus_reqack = 1'b0;
        resp_beats(1'b0, BEATS, 64'd0, 1'b1);
        bus_respcyc = 1'b1; r0_respack = 1'b1; bus_resp = 64'hDEAD;
        #1;
        chk("spur_respack", 64'(bus_respack), 64'd0);
        chk("spur_r0_respcyc", 64'(r0_respcyc), 64'd0);
        chk("spur_r1_respcyc", 64'(r1_respcyc), 64'd0);
        chk("spur_r0_resp", r0_resp, 64'd0);
        bus_respcyc = 1'b0; r0_respack = 1'b0; bus_resp = '0;
        tick();

        // r1 write, 9 beats with two stall cycles before each, plus an owner drop
        r1_reqcyc = 1'b1; r1_req = 64'hA000; r1_reqtag = 13'h1007;
        #1;
        chk("wr_idle_noreq", 64'(bus_reqcyc), 64'd0);
        tick();
        acks = 0;
        for (int b = 0; b < BEATS + 1; b++) begin
            r1_req = 64'hA000 + 64'(b);
            for (int s = 0; s < 2; s++) begin
                bus_reqack = 1'b0;
                #1;
                chk("wr_stall_cyc", 64'(bus_reqcyc), 64'd1);
                chk("wr_stall_data", bus_req, 64'hA000 + 64'(b));
                acks += int'(r1_reqack);
                tick();
            end
            if (b == 4) begin
                r1_reqcyc = 1'b0; bus_reqack = 1'b1;
                #1;
                chk("wr_drop_cyc", 64'(bus_reqcyc), 64'd0);
                chk("wr_drop_data", bus_req, 64'd0);
                tick();
                r1_reqcyc = 1'b1;
            end
            bus_reqack = 1'b1;
            #1;
            acks += int'(r1_reqack);
            chk("wr_tag", 64'(bus_reqtag), 64'h1007);
            chk("wr_r0_noack", 64'(r0_reqack), 64'd0);
            tick();
        end
        bus_reqack = 1'b0;
        r0_reqcyc = 1'b1; r0_req = 64'hB000; r0_reqtag = 13'h0011;
        bus_respcyc = 1'b1; r1_respack = 1'b1;
        #1;
        chk("wr_ack_count", 64'(acks), 64'd9);
        chk("wr_done_idle", 64'(bus_reqcyc), 64'd0);
        chk("wr_no_resp_ack", 64'(bus_respack), 64'd0);
        chk("wr_no_respcyc", 64'(r1_respcyc), 64'd0);
        tick();
        bus_respcyc = 1'b0; r1_respack = 1'b0;
        #1;
        chk("wr_rr_grant_r0", bus_req, 64'hB000);
        chk("wr_rr_cyc", 64'(bus_reqcyc), 64'd1);

        // Reset mid-REQ, then contention after reset
        reset = 1'b0;
        #1;
        chk("rst_mid_cyc", 64'(bus_reqcyc), 64'd0);
        tick();
        reset = 1'b1;
        r1_req = 64'hC000; r1_reqtag = 13'h0021;
        bus_reqack = 1'b1;
        #1;
        chk("both_idle", 64'(bus_reqcyc), 64'd0);
        chk("both_idle_ack", 64'(r0_reqack | r1_reqack), 64'd0);
        tick();
        chk("both_grant_r0", bus_req, 64'hB000);
        chk("both_r0_ack", 64'(r0_reqack), 64'd1);
        chk("both_r1_pend", 64'(r1_reqack), 64'd0);
        tick();
        r0_reqcyc = 1'b0;
        resp_beats(1'b0, BEATS, 64'h100, 1'b0);
        #1;
        chk("r1_wait_idle", 64'(bus_reqcyc), 64'd0);
        chk("r1_wait_ack", 64'(r1_reqack), 64'd0);
        tick();
        chk("r1_grant", 64'(bus_reqcyc), 64'd1);
        chk("r1_addr", bus_req, 64'hC000);
        chk("r1_ack", 64'(r1_reqack), 64'd1);
        chk("r1_r0_noack", 64'(r0_reqack), 64'd0);
        tick();
        r1_reqcyc = 1'b0; bus_reqack = 1'b0;
        resp_beats(1'b1, 3, 64'h200, 1'b0);

        // Reset lands on the 4th response beat
        bus_respcyc = 1'b1; bus_resp = 64'h203; r1_respack = 1'b1; reset = 1'b0;
        #1;
        chk("rst4_respcyc", 64'(r1_respcyc), 64'd0);
        chk("rst4_respack", 64'(bus_respack), 64'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("post_rst_respcyc", 64'(r1_respcyc | r0_respcyc), 64'd0);
        chk("post_rst_respack", 64'(bus_respack), 64'd0);
        chk("post_rst_resp", r1_resp, 64'd0);
        chk("post_rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        bus_respcyc = 1'b0; bus_resp = '0; r1_respack = 1'b0;

        // Fresh r1 read completes normally
        r1_reqcyc = 1'b1; r1_req = 64'hD000; r1_reqtag = 13'h0022;
        tick();
        bus_reqack = 1'b1;
        #1;
        chk("new_grant", 64'(bus_reqcyc), 64'd1);
        chk("new_addr", bus_req, 64'hD000);
        chk("new_ack", 64'(r1_reqack), 64'd1);
        tick();
        r1_reqcyc = 1'b0; bus_reqack = 1'b0;
        resp_beats(1'b1, BEATS, 64'h300, 1'b0);
        bus_respcyc = 1'b1; r1_respack = 1'b1;
        #1;
        chk("new_done_idle", 64'(bus_respack), 64'd0);
        chk("new_done_respcyc", 64'(r1_respcyc), 64'd0);
        bus_respcyc = 1'b0; r1_respack = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
